// File: rtl/tile_dispatcher_pkg.sv
// Shared encodings for the tile dispatcher: command types and FSM states.
package tile_dispatcher_pkg;

  typedef enum logic [2:0] {
    CMD_ADDR  = 3'd0,
    CMD_ZOOM  = 3'd1,
    CMD_REAL  = 3'd2,
    CMD_IMAG  = 3'd3,
    CMD_START = 3'd4,
    CMD_ABORT = 3'd5
  } cmd_type_e;

  typedef enum logic {
    SEARCH = 1'b0,
    LOAD   = 1'b1
  } state_e;

endpackage

// File: rtl/tile_dispatcher_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import tile_dispatcher_pkg::*;
#(
  parameter int NUM_SOLVERS = 4,
  parameter int IDX_W       = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1
) (
  input  logic [NUM_SOLVERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_SOLVERS]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(ptr) + i) % NUM_SOLVERS);
      end
    end
  end

endmodule

// File: rtl/tile_dispatcher.sv
// Streams tile configuration and limbs from a command port into one reserved
// solver at a time, picking solvers round-robin.
module tile_dispatcher
  import tile_dispatcher_pkg::*;
#(
  parameter int NUM_SOLVERS     = 4,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27,
  parameter int MAX_LIMBS       = 2 ** LIMB_INDEX_BITS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [2:0]                    cmd_type,
  input  logic [31:0]                   cmd_data,
  output logic                          cmd_ready,
  input  logic [NUM_SOLVERS-1:0]        solver_ready,
  output logic [NUM_SOLVERS-1:0]        solver_write_real_en,
  output logic [NUM_SOLVERS-1:0]        solver_write_imag_en,
  output logic [NUM_SOLVERS-1:0]        solver_start,
  output logic [LIMB_INDEX_BITS-1:0]    solver_write_limb,
  output logic [LIMB_SIZE_BITS-1:0]     solver_write_data,
  output logic [32*NUM_SOLVERS-1:0]     solver_output_addr,
  output logic [32*NUM_SOLVERS-1:0]     solver_zoom_level,
  output logic [31:0]                   tiles_dispatched,
  output logic                          error
);

  localparam int IDX_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  // One extra bit so the counter can sit at MAX_LIMBS and flag overflow.
  localparam int CNT_W = LIMB_INDEX_BITS + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LIMBS);

  state_e                        state;
  logic [IDX_W-1:0]              rr_ptr;
  logic [IDX_W-1:0]              sel;
  logic [CNT_W-1:0]              real_cnt;
  logic [CNT_W-1:0]              imag_cnt;
  logic [NUM_SOLVERS-1:0][31:0]  addr_q;
  logic [NUM_SOLVERS-1:0][31:0]  zoom_q;
  logic                          grant_valid;
  logic [IDX_W-1:0]              grant_idx;
  logic                          xfer;
  logic [NUM_SOLVERS-1:0]        sel_mask;

  rr_arbiter #(
    .NUM_SOLVERS (NUM_SOLVERS),
    .IDX_W       (IDX_W)
  ) u_arb (
    .req         (solver_ready),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign solver_output_addr = addr_q;
  assign solver_zoom_level  = zoom_q;
  assign solver_write_data  = cmd_data[LIMB_SIZE_BITS-1:0];

  always_comb begin
    xfer     = cmd_valid & cmd_ready;
    sel_mask = NUM_SOLVERS'(1) << sel;
    solver_write_real_en = '0;
    solver_write_imag_en = '0;
    solver_start         = '0;
    solver_write_limb    = (cmd_type == CMD_IMAG) ? imag_cnt[LIMB_INDEX_BITS-1:0]
                                                  : real_cnt[LIMB_INDEX_BITS-1:0];
    if (xfer) begin
      if (cmd_type == CMD_REAL && real_cnt != MAX_CNT) solver_write_real_en = sel_mask;
      if (cmd_type == CMD_IMAG && imag_cnt != MAX_CNT) solver_write_imag_en = sel_mask;
      if (cmd_type == CMD_START)                       solver_start         = sel_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= SEARCH;
      cmd_ready        <= 1'b0;
      rr_ptr           <= '0;
      sel              <= '0;
      real_cnt         <= '0;
      imag_cnt         <= '0;
      addr_q           <= '0;
      zoom_q           <= '0;
      tiles_dispatched <= '0;
      error            <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (grant_valid) begin
            sel       <= grant_idx;
            real_cnt  <= '0;
            imag_cnt  <= '0;
            state     <= LOAD;
            cmd_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            case (cmd_type)
              CMD_ADDR: addr_q[sel] <= cmd_data;
              CMD_ZOOM: zoom_q[sel] <= cmd_data;
              CMD_REAL: begin
                if (real_cnt == MAX_CNT) error <= 1'b1;
                else                     real_cnt <= real_cnt + 1'b1;
              end
              CMD_IMAG: begin
                if (imag_cnt == MAX_CNT) error <= 1'b1;
                else                     imag_cnt <= imag_cnt + 1'b1;
              end
              CMD_START: begin
                tiles_dispatched <= tiles_dispatched + 32'd1;
                rr_ptr    <= (sel == IDX_W'(NUM_SOLVERS - 1)) ? '0 : sel + IDX_W'(1);
                state     <= SEARCH;
                cmd_ready <= 1'b0;
              end
              CMD_ABORT: begin
                state     <= SEARCH;
                cmd_ready <= 1'b0;
              end
              default: error <= 1'b1;
            endcase
          end
        end
        default: begin
          state     <= SEARCH;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_dispatcher.sv
// Directed bench for tile_dispatcher: 4 solvers, MAX_LIMBS shrunk to 4.
module tb_tile_dispatcher;
  import tile_dispatcher_pkg::*;

  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [2:0]    cmd_type;
  logic [31:0]   cmd_data;
  logic          cmd_ready;
  logic [N-1:0]  solver_ready;
  logic [N-1:0]  solver_write_real_en;
  logic [N-1:0]  solver_write_imag_en;
  logic [N-1:0]  solver_start;
  logic [5:0]    solver_write_limb;
  logic [26:0]   solver_write_data;
  logic [32*N-1:0] solver_output_addr;
  logic [32*N-1:0] solver_zoom_level;
  logic [31:0]   tiles_dispatched;
  logic          error;

  int checks = 0;
  int errors = 0;

  tile_dispatcher #(
    .NUM_SOLVERS     (N),
    .LIMB_INDEX_BITS (6),
    .LIMB_SIZE_BITS  (27),
    .MAX_LIMBS       (4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .cmd_valid            (cmd_valid),
    .cmd_type             (cmd_type),
    .cmd_data             (cmd_data),
    .cmd_ready            (cmd_ready),
    .solver_ready         (solver_ready),
    .solver_write_real_en (solver_write_real_en),
    .solver_write_imag_en (solver_write_imag_en),
    .solver_start         (solver_start),
    .solver_write_limb    (solver_write_limb),
    .solver_write_data    (solver_write_data),
    .solver_output_addr   (solver_output_addr),
    .solver_zoom_level    (solver_zoom_level),
    .tiles_dispatched     (tiles_dispatched),
    .error                (error)
  );

  always #5 clock = ~clock;

  task automatic put(input logic [2:0] t, input logic [31:0] d);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b0 || error !== 1'b0 || tiles_dispatched !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: ready=%b error=%b tiles=%0d, expected 0 0 0", cmd_ready, error, tiles_dispatched);
    end
    checks++;
    if (solver_output_addr !== '0 || solver_zoom_level !== '0) begin
      errors++;
      $display("FAIL reset_cfg: addr=%h zoom=%h, expected 0", solver_output_addr, solver_zoom_level);
    end
    reset = 1'b0;
  endtask

  task automatic test_no_ready();
    for (int i = 0; i < 3; i++) begin
      put(CMD_START, 32'd0);
      checks++;
      if (cmd_ready !== 1'b0 || solver_start !== 4'b0000) begin
        errors++;
        $display("FAIL idle_valid: ready=%b start=%b, expected 0 0000", cmd_ready, solver_start);
      end
      tick();
    end
    checks++;
    if (tiles_dispatched !== 32'd0) begin
      errors++;
      $display("FAIL idle_tiles: got %0d expected 0", tiles_dispatched);
    end
    solver_ready = 4'b1111;
  endtask

  task automatic test_single_tile();
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_wait: cmd_ready never rose"); end
    put(CMD_ADDR, 32'h0000_1000); tick();
    put(CMD_ZOOM, 32'd5); tick();
    for (int k = 0; k < 3; k++) begin
      put(CMD_REAL, 32'h0AA0_0000 + k);
      checks++;
      if (solver_write_real_en !== 4'b0001 || solver_write_imag_en !== 4'b0000 ||
          solver_write_limb !== 6'(k) || solver_write_data !== 27'h2A0_0000 + 27'(k)) begin
        errors++;
        $display("FAIL real_limb%0d: re=%b im=%b limb=%0d data=%h, expected 0001 0000 %0d %h",
                 k, solver_write_real_en, solver_write_imag_en, solver_write_limb,
                 solver_write_data, k, 27'h2A0_0000 + 27'(k));
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      put(CMD_IMAG, 32'h55 + k);
      checks++;
      if (solver_write_imag_en !== 4'b0001 || solver_write_real_en !== 4'b0000 ||
          solver_write_limb !== 6'(k)) begin
        errors++;
        $display("FAIL imag_limb%0d: im=%b re=%b limb=%0d, expected 0001 0000 %0d",
                 k, solver_write_imag_en, solver_write_real_en, solver_write_limb, k);
      end
      tick();
    end
    checks++;
    if (solver_output_addr[31:0] !== 32'h1000 || solver_zoom_level[31:0] !== 32'd5) begin
      errors++;
      $display("FAIL cfg0: addr=%h zoom=%0d, expected 1000 5", solver_output_addr[31:0], solver_zoom_level[31:0]);
    end
    put(CMD_START, 32'd0);
    checks++;
    if (solver_start !== 4'b0001) begin
      errors++;
      $display("FAIL start0: got %b expected 0001", solver_start);
    end
    tick();
    checks++;
    if (solver_start !== 4'b0000 || tiles_dispatched !== 32'd1) begin
      errors++;
      $display("FAIL after_start0: start=%b tiles=%0d, expected 0000 1", solver_start, tiles_dispatched);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_wait: cmd_ready never rose"); end
    put(CMD_ADDR, 32'h0000_2000); tick();
    put(CMD_START, 32'd0);
    checks++;
    if (solver_start !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_start1: got %b expected 0010", solver_start);
    end
    tick();
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: cmd_ready=%b expected 0", cmd_ready);
    end
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reload: cmd_ready=%b expected 1", cmd_ready);
    end
    checks++;
    if (solver_output_addr[63:32] !== 32'h2000) begin
      errors++;
      $display("FAIL cfg1: addr=%h expected 2000", solver_output_addr[63:32]);
    end
    solver_ready = 4'b0100;
    put(CMD_START, 32'd0);
    checks++;
    if (solver_start !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_start2: got %b expected 0100", solver_start);
    end
    tick();
  endtask

  task automatic test_wrap();
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_wait: cmd_ready never rose"); end
    solver_ready = 4'b1111;
    put(CMD_START, 32'd0);
    checks++;
    if (solver_start !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_sel: got %b expected 0100", solver_start);
    end
    tick();
    checks++;
    if (tiles_dispatched !== 32'd4) begin
      errors++;
      $display("FAIL wrap_tiles: got %0d expected 4", tiles_dispatched);
    end
  endtask

  task automatic test_limb_overflow();
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_wait: cmd_ready never rose"); end
    for (int k = 0; k < 4; k++) begin
      put(CMD_REAL, 32'h100 + k);
      checks++;
      if (solver_write_real_en !== 4'b1000 || solver_write_limb !== 6'(k)) begin
        errors++;
        $display("FAIL ovf_limb%0d: re=%b limb=%0d, expected 1000 %0d", k, solver_write_real_en, solver_write_limb, k);
      end
      tick();
    end
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early_error: got %b expected 0", error);
    end
    put(CMD_REAL, 32'h104);
    checks++;
    if (solver_write_real_en !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_drop: re=%b expected 0000", solver_write_real_en);
    end
    tick();
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL ovf_error: got %b expected 1", error);
    end
    put(CMD_ABORT, 32'd0);
    checks++;
    if (solver_start !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_abort: start=%b expected 0000", solver_start);
    end
    tick();
  endtask

  task automatic test_abort();
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_wait: cmd_ready never rose"); end
    for (int k = 0; k < 2; k++) begin
      put(CMD_REAL, 32'h200 + k);
      checks++;
      if (solver_write_real_en !== 4'b1000 || solver_write_limb !== 6'(k)) begin
        errors++;
        $display("FAIL abort_limb%0d: re=%b limb=%0d, expected 1000 %0d", k, solver_write_real_en, solver_write_limb, k);
      end
      tick();
    end
    put(CMD_ABORT, 32'd0);
    checks++;
    if (solver_start !== 4'b0000) begin
      errors++;
      $display("FAIL abort_start: got %b expected 0000", solver_start);
    end
    tick();
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_rewait: cmd_ready never rose"); end
    put(CMD_REAL, 32'h300);
    checks++;
    if (solver_write_real_en !== 4'b1000 || solver_write_limb !== 6'd0) begin
      errors++;
      $display("FAIL abort_restart: re=%b limb=%0d, expected 1000 0", solver_write_real_en, solver_write_limb);
    end
    tick();
    put(CMD_START, 32'd0);
    checks++;
    if (solver_start !== 4'b1000) begin
      errors++;
      $display("FAIL abort_newtile: start=%b expected 1000", solver_start);
    end
    tick();
    checks++;
    if (tiles_dispatched !== 32'd5) begin
      errors++;
      $display("FAIL abort_tiles: got %0d expected 5", tiles_dispatched);
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_wait: cmd_ready never rose"); end
    put(CMD_ADDR, 32'h0000_ABCD); tick();
    checks++;
    if (solver_output_addr[31:0] !== 32'hABCD) begin
      errors++;
      $display("FAIL rst_precfg: addr=%h expected abcd", solver_output_addr[31:0]);
    end
    put(CMD_REAL, 32'h1); tick();
    @(negedge clock);
    reset = 1'b1;
    solver_ready = 4'b0000;
    @(posedge clock);
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || error !== 1'b0 || tiles_dispatched !== 32'd0 ||
        solver_write_limb !== 6'd0 || solver_start !== 4'b0000 ||
        solver_write_real_en !== 4'b0000 || solver_write_imag_en !== 4'b0000) begin
      errors++;
      $display("FAIL rst_outputs: ready=%b err=%b tiles=%0d limb=%0d st=%b re=%b im=%b, expected all 0",
               cmd_ready, error, tiles_dispatched, solver_write_limb, solver_start,
               solver_write_real_en, solver_write_imag_en);
    end
    checks++;
    if (solver_output_addr !== '0 || solver_zoom_level !== '0) begin
      errors++;
      $display("FAIL rst_cfg: addr=%h zoom=%h, expected 0", solver_output_addr, solver_zoom_level);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(CMD_START, 32'd0);
      checks++;
      if (solver_start !== 4'b0000) begin
        errors++;
        $display("FAIL rst_nostart: got %b expected 0000", solver_start);
      end
      tick();
    end
    checks++;
    if (tiles_dispatched !== 32'd0) begin
      errors++;
      $display("FAIL rst_tiles: got %0d expected 0", tiles_dispatched);
    end
  endtask

  task automatic test_reserved();
    bit ok;
    solver_ready = 4'b1111;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rsv_wait: cmd_ready never rose"); end
    put(3'd6, 32'hFFFF_FFFF);
    checks++;
    if ((solver_write_real_en | solver_write_imag_en | solver_start) !== 4'b0000) begin
      errors++;
      $display("FAIL rsv_strobe: re=%b im=%b st=%b, expected 0", solver_write_real_en, solver_write_imag_en, solver_start);
    end
    tick();
    checks++;
    if (error !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsv_error: error=%b ready=%b, expected 1 1", error, cmd_ready);
    end
    put(3'd7, 32'd0); tick();
    put(CMD_REAL, 32'h7);
    checks++;
    if (solver_write_real_en !== 4'b0001 || solver_write_limb !== 6'd0) begin
      errors++;
      $display("FAIL rsv_limb: re=%b limb=%0d, expected 0001 0", solver_write_real_en, solver_write_limb);
    end
    tick();
    put(CMD_START, 32'd0);
    checks++;
    if (solver_start !== 4'b0001) begin
      errors++;
      $display("FAIL rsv_start: got %b expected 0001", solver_start);
    end
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_type     = 3'd0;
    cmd_data     = 32'd0;
    solver_ready = 4'b0000;
    repeat (2) @(posedge clock);
    test_reset();
    test_no_ready();
    test_single_tile();
    test_back_to_back();
    test_wrap();
    test_limb_overflow();
    test_abort();
    test_reset_mid_load();
    test_reserved();
    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
